// File: rtl/clock_pkg.sv
// Shared constants for the alarm-clock button front end.
// Button index positions within btn_raw / btn_lvl / btn_rise.
package clock_pkg;

    localparam int NB_DEFAULT = 7;

    localparam int BTN_TIMESET  = 0;
    localparam int BTN_ALARMSET = 1;
    localparam int BTN_MINADV   = 2;
    localparam int BTN_HRSADV   = 3;
    localparam int BTN_DAYADV   = 4;
    localparam int BTN_DATADV   = 5;
    localparam int BTN_MONADV   = 6;

endpackage

// File: rtl/debounce_1b.sv
// One button channel: two-flop synchronizer followed by a stability counter.
// The level only moves after DB_CYC consecutive cycles of disagreement.
module debounce_1b #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl
);

    localparam int              CW       = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYC - 1);

    logic          meta;
    logic          s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            cnt  <= '0;
            lvl  <= 1'b0;
        end else begin
            meta <= raw;
            s    <= meta;
            // Any return to the current level throws away the partial count.
            if (s == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the clock's setting buttons, flags their rising edges and
// produces the free-running Pulse tick from the system clock.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DIV    = 50_000_000,
    parameter int DB_CYC = 1_000_000,
    parameter int NB     = NB_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NB-1:0] btn_raw,
    output logic [NB-1:0] btn_lvl,
    output logic [NB-1:0] btn_rise,
    output logic          pulse
);

    localparam int            PW        = $clog2(DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_PRE  = PW'(DIV - 2);

    logic [NB-1:0] lvl_d;
    logic [PW-1:0] pcnt;

    for (genvar i = 0; i < NB; i++) begin : g_ch
        debounce_1b #(
            .DB_CYC(DB_CYC)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(btn_raw[i]),
            .lvl(btn_lvl[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d <= '0;
        end else begin
            lvl_d <= btn_lvl;
        end
    end

    // Formed purely from two flops, so the strobe is glitch-free and lines up
    // with the first cycle of the new level.
    assign btn_rise = btn_lvl & ~lvl_d;

    // pulse is registered one count early so it is high exactly while pcnt == DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            pcnt  <= (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
            pulse <= (pcnt == PCNT_PRE);
        end
    end

endmodule
